bombe_hit_collector: RTL

BOMBE_HIT_COLLECTOR -- requirements
Module: bombe_hit_collector

---
 rtl/bombe_hit_collector_pkg.sv | 15 +
 rtl/bombe_hit_collector_if.sv | 11 +
 rtl/bombe_hit_fifo.sv | 73 +++++++
 rtl/bombe_hit_collector.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bombe_hit_collector_pkg.sv
// rtl/bombe_hit_collector_pkg.sv - shared widths and hit record for the bombe hit collector
package bombe_pkg;

    localparam int ROTOR_SEL_W = 9;
    localparam int ROTOR_POS_W = 15;
    localparam int CHAN_W      = 3;

    // One buffered hit; "initial" is a keyword, so the start positions live in initial_pos.
    typedef struct packed {
        logic [CHAN_W-1:0]      channel;
        logic [ROTOR_SEL_W-1:0] select;
        logic [ROTOR_POS_W-1:0] initial_pos;
    } bombe_hit_t;

endpackage

// File: rtl/bombe_hit_collector_if.sv
// rtl/bombe_hit_collector_if.sv - result stream handshake between the hit FIFO and its consumer
interface bombe_hit_collector_if
    import bombe_pkg::*;
();
    logic       valid;
    logic       ready;
    bombe_hit_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bombe_hit_fifo.sv
// rtl/bombe_hit_fifo.sv - first-word-fall-through result FIFO with occupancy count
module bombe_hit_fifo
    import bombe_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     clear_in,
    input  logic                     push_in,
    input  bombe_hit_t               push_data_in,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   count_out,
    bombe_hit_collector_if.master    res
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    bombe_hit_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          pop;
    logic          push;

    assign empty_out = (count_q == '0);
    assign full_out  = (count_q == FULL_CNT);
    assign count_out = count_q;
    assign res.valid = !empty_out;
    // Head is forced to zero when empty so the data outputs read 0 in reset.
    assign res.data  = empty_out ? '0 : mem_q[rd_ptr_q];

    // A full FIFO still accepts a push in the same cycle as a pop.
    assign pop  = res.valid && res.ready && !clear_in;
    assign push = push_in && !clear_in && (!full_out || pop);

    // Occupancy next state: push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_in;
        end
    end

    // Pointers wrap naturally at DEPTH; clear flushes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bombe_hit_collector.sv
// rtl/bombe_hit_collector.sv - gathers per-channel bombe hits into one round-robin result FIFO
module bombe_hit_collector
    import bombe_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int DEDUP  = 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          clear_in,
    input  logic [NUM_CH-1:0]             hit_valid_in,
    input  logic [NUM_CH*ROTOR_SEL_W-1:0] hit_select_in,
    input  logic [NUM_CH*ROTOR_POS_W-1:0] hit_initial_in,
    input  logic                          result_ready_in,
    output logic                          result_valid_out,
    output logic [ROTOR_SEL_W-1:0]        result_select_out,
    output logic [ROTOR_POS_W-1:0]        result_initial_out,
    output logic [CHAN_W-1:0]             result_channel_out,
    output logic [6:0]                    count_out,
    output logic [7:0]                    drop_count_out,
    output logic                          overflow_out
);
    localparam int         CW  = $clog2(DEPTH) + 1;
    localparam logic [3:0] NCH = 4'(NUM_CH);

    bombe_hit_collector_if res_if ();

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic                   push;
    bombe_hit_t             push_data;

    logic [NUM_CH-1:0]      pend_vld_q;
    logic [NUM_CH-1:0]      pend_vld_d;
    logic [NUM_CH-1:0]      load;
    logic [ROTOR_SEL_W-1:0] pend_sel_q  [NUM_CH];
    logic [ROTOR_POS_W-1:0] pend_init_q [NUM_CH];

    logic [CHAN_W-1:0]      rr_q;
    logic                   last_vld_q;
    logic [ROTOR_SEL_W-1:0] last_sel_q;
    logic [ROTOR_POS_W-1:0] last_init_q;
    logic [7:0]             drop_q;
    logic [7:0]             drop_d;
    logic                   ovf_q;
    logic                   ovf_d;

    logic                   can_grant;
    logic                   gnt_vld;
    logic [CHAN_W-1:0]      gnt_idx;
    logic [3:0]             cand;
    logic [ROTOR_SEL_W-1:0] gnt_sel;
    logic [ROTOR_POS_W-1:0] gnt_init;
    logic                   dup;
    logic [3:0]             n_drop;
    logic [8:0]             drop_sum;

    // Granting into a full FIFO is legal only when the head leaves this cycle.
    assign can_grant = !clear_in && (!fifo_full || (res_if.valid && result_ready_in));

    // Round-robin search starting at the channel after the last grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        cand    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = {1'b0, rr_q} + 4'(k);
            if (cand >= NCH) cand = cand - NCH;
            for (int c = 0; c < NUM_CH; c++) begin
                if (can_grant && !gnt_vld && (cand == 4'(c)) && pend_vld_q[c]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = CHAN_W'(c);
                end
            end
        end
    end

    // Pending next state, drop accounting and granted-entry selection.
    always_comb begin
        pend_vld_d = pend_vld_q;
        load       = '0;
        n_drop     = '0;
        gnt_sel    = '0;
        gnt_init   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_vld && (gnt_idx == CHAN_W'(c))) begin
                gnt_sel  = pend_sel_q[c];
                gnt_init = pend_init_q[c];
            end
            if (clear_in) begin
                pend_vld_d[c] = 1'b0;
            end else if (hit_valid_in[c]) begin
                // A hit may refill the slot that is being granted this cycle.
                if (!pend_vld_q[c] || (gnt_vld && (gnt_idx == CHAN_W'(c)))) begin
                    load[c]       = 1'b1;
                    pend_vld_d[c] = 1'b1;
                end else begin
                    n_drop = n_drop + 4'd1;
                end
            end else if (gnt_vld && (gnt_idx == CHAN_W'(c))) begin
                pend_vld_d[c] = 1'b0;
            end
        end
        drop_sum = {1'b0, drop_q} + {5'b0, n_drop};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        ovf_d    = ovf_q || (n_drop != 4'd0);
    end

    // A repeat of the last written hit is retired without a FIFO write.
    assign dup       = (DEDUP != 0) && last_vld_q && (gnt_sel == last_sel_q) && (gnt_init == last_init_q);
    assign push      = gnt_vld && !dup;
    assign push_data = '{channel: gnt_idx, select: gnt_sel, initial_pos: gnt_init};

    // Pending payloads need no reset; the valid flags gate them.
    always_ff @(posedge clk_in) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (load[c]) begin
                pend_sel_q[c]  <= hit_select_in[c*ROTOR_SEL_W +: ROTOR_SEL_W];
                pend_init_q[c] <= hit_initial_in[c*ROTOR_POS_W +: ROTOR_POS_W];
            end
        end
    end

    // Control state: pending flags, arbiter pointer, dedup memory and drop counters.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pend_vld_q  <= '0;
            rr_q        <= '0;
            last_vld_q  <= 1'b0;
            last_sel_q  <= '0;
            last_init_q <= '0;
            drop_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pend_vld_q <= pend_vld_d;
            if (clear_in) begin
                last_vld_q <= 1'b0;
                drop_q     <= '0;
                ovf_q      <= 1'b0;
            end else begin
                drop_q <= drop_d;
                ovf_q  <= ovf_d;
                if (gnt_vld) rr_q <= gnt_idx;
                if (push) begin
                    last_vld_q  <= 1'b1;
                    last_sel_q  <= gnt_sel;
                    last_init_q <= gnt_init;
                end
            end
        end
    end

    bombe_hit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .clear_in     (clear_in),
        .push_in      (push),
        .push_data_in (push_data),
        .full_out     (fifo_full),
        .empty_out    (fifo_empty),
        .count_out    (fifo_count),
        .res          (res_if)
    );

    assign res_if.ready       = result_ready_in;
    assign result_valid_out   = !fifo_empty;
    assign result_select_out  = res_if.data.select;
    assign result_initial_out = res_if.data.initial_pos;
    assign result_channel_out = res_if.data.channel;
    assign count_out          = 7'(fifo_count);
    assign drop_count_out     = drop_q;
    assign overflow_out       = ovf_q;

endmodule
